w0rm_peripheral_bus_arbiter: RTL and testbench
==============================================

W0RM_PERIPHERAL_BUS_ARBITER -- requirements
Module: w0rm_peripheral_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of all data buses.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, max WAIT cycles before error completion; legal range 1..255.
REQ-004 SHALL have port mem_clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port cpu_reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have, per requester n in {0,1}: mN_valid_i in 1 (request), mN_read_i in 1, mN_write_i in 1, mN_addr_i in ADDR_WIDTH, mN_data_i in DATA_WIDTH (write data).
REQ-007 SHALL have, per requester n: mN_accept_o out 1 (request taken this cycle), mN_valid_o out 1 (response strobe), mN_data_o out DATA_WIDTH (read data), mN_err_o out 1 (timeout flag, qualified by mN_valid_o).
REQ-008 SHALL have slave-side outputs mem_valid_o 1, mem_read_o 1, mem_write_o 1, mem_addr_o ADDR_WIDTH, mem_data_o DATA_WIDTH.
REQ-009 SHALL have slave-side inputs mem_valid_i 1 (peripheral acknowledge) and mem_data_i DATA_WIDTH (peripheral read data).

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding.
REQ-011 IDLE: if any mN_valid_i high, SHALL grant one requester, assert its mN_accept_o combinationally that cycle, capture its read/write/addr/data, go ISSUE; else stay IDLE.
REQ-012 Arbitration SHALL be round-robin: single requester always wins; both requesting -> requester not granted last wins; last-grant pointer updates only on grant.
REQ-013 mN_accept_o SHALL be high only in IDLE and at most one accept high per cycle.
REQ-014 ISSUE: mem_valid_o high for exactly one cycle with captured mem_read_o/mem_write_o/mem_addr_o/mem_data_o; clear WAIT counter; go WAIT.
REQ-015 mem_valid_o, mem_read_o, mem_write_o SHALL be 0 in all states except ISSUE; mem_addr_o/mem_data_o hold captured values.
REQ-016 WAIT: on mem_valid_i high, capture mem_data_i, clear error, go RESP.
REQ-017 WAIT: without mem_valid_i, increment counter; when counter reaches TIMEOUT_CYCLES, set captured data to 0, set error, go RESP.
REQ-018 mem_valid_i and timeout in same cycle: acknowledge SHALL win (no error).
REQ-019 mem_valid_i outside WAIT SHALL be ignored.
REQ-020 RESP: granted requester's mN_valid_o high one cycle with mN_data_o and mN_err_o; other requester's outputs stay 0; go IDLE.
REQ-021 Writes SHALL complete identically to reads (peripheral ack required); mN_data_o on write completion = captured mem_data_i.
REQ-022 Latency with one-cycle-ack peripheral: accept at cycle T, mem_valid_o at T+1, ack at T+2, mN_valid_o at T+3; next accept earliest T+4.
REQ-023 mN_data_o/mN_err_o SHALL be 0 when mN_valid_o low.
REQ-024 Requester deasserting mN_valid_i after accept SHALL not affect the captured transaction.

Reset
REQ-025 cpu_reset low SHALL asynchronously force IDLE, counter 0, last-grant pointer = requester 1 (so requester 0 wins first contention), captured fields 0, error 0.
REQ-026 All outputs SHALL be 0 during reset; reset mid-transaction SHALL abandon it with no response strobe.
REQ-027 First grant possible in the first rising edge after cpu_reset deasserts.

Structure
REQ-028 Shared package w0rm_periph_bus_pkg SHALL hold FSM state encoding, default TIMEOUT_CYCLES, and counter width (8).
REQ-029 Round-robin grant logic SHALL be a sub-module w0rm_rr_arb2 (inputs req[1:0], last pointer; outputs one-hot grant).
REQ-030 Counter SHALL be 8 bits, saturating at TIMEOUT_CYCLES, never wrapping.

Verification
REQ-031 m0 read addr 0x80000088, peripheral acks next cycle with 0x000000A5 -> m0_accept_o at T, mem_valid_o at T+1, m0_valid_o at T+3, m0_data_o=0x000000A5, m0_err_o=0.
REQ-032 m0 and m1 request continuously from reset -> grants alternate m0,m1,m0,m1; no double accept in any cycle.
REQ-033 m1 write 0x000000FF to 0x8000008C, peripheral acks -> mem_write_o=1, mem_data_o=0x000000FF for one cycle; m1_valid_o one cycle, m1_err_o=0.
REQ-034 m0 read 0x90000000, no ack -> m0_valid_o after 15 WAIT cycles, m0_data_o=0, m0_err_o=1; next request served normally.
REQ-035 ack arriving on the same cycle counter hits TIMEOUT_CYCLES -> m0_err_o=0, data = mem_data_i.
REQ-036 cpu_reset low during WAIT -> all outputs 0 immediately, no mN_valid_o; after release, m0 request accepted on first edge.

Source files
------------

// File: rtl/w0rm_peripheral_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester peripheral bus arbiter.
package w0rm_periph_bus_pkg;

  // Default number of WAIT cycles before a transaction completes with an error
  localparam int unsigned DEF_TIMEOUT_CYCLES = 15;

  // Width of the WAIT-state cycle counter
  localparam int unsigned CNT_WIDTH = 8;

  // Number of requesters arbitrated
  localparam int unsigned NUM_REQ = 2;

  // Transaction sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Captured command type of the outstanding transaction
  typedef struct packed {
    logic rd;
    logic wr;
  } cmd_t;

endpackage : w0rm_periph_bus_pkg

// File: rtl/w0rm_peripheral_bus_arbiter_if.sv
// Requester-side and peripheral-side signal bundle of the bus arbiter.
interface w0rm_peripheral_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  // Requester 0
  logic                  m0_valid_i;
  logic                  m0_read_i;
  logic                  m0_write_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic [DATA_WIDTH-1:0] m0_data_i;
  logic                  m0_accept_o;
  logic                  m0_valid_o;
  logic [DATA_WIDTH-1:0] m0_data_o;
  logic                  m0_err_o;

  // Requester 1
  logic                  m1_valid_i;
  logic                  m1_read_i;
  logic                  m1_write_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic [DATA_WIDTH-1:0] m1_data_i;
  logic                  m1_accept_o;
  logic                  m1_valid_o;
  logic [DATA_WIDTH-1:0] m1_data_o;
  logic                  m1_err_o;

  // Peripheral side
  logic                  mem_valid_o;
  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic                  mem_valid_i;
  logic [DATA_WIDTH-1:0] mem_data_i;

  // Arbiter view
  modport slave (
    input  m0_valid_i, m0_read_i, m0_write_i, m0_addr_i, m0_data_i,
    output m0_accept_o, m0_valid_o, m0_data_o, m0_err_o,
    input  m1_valid_i, m1_read_i, m1_write_i, m1_addr_i, m1_data_i,
    output m1_accept_o, m1_valid_o, m1_data_o, m1_err_o,
    output mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_valid_i, mem_data_i
  );

  // Environment view (requesters and peripheral)
  modport master (
    output m0_valid_i, m0_read_i, m0_write_i, m0_addr_i, m0_data_i,
    input  m0_accept_o, m0_valid_o, m0_data_o, m0_err_o,
    output m1_valid_i, m1_read_i, m1_write_i, m1_addr_i, m1_data_i,
    input  m1_accept_o, m1_valid_o, m1_data_o, m1_err_o,
    input  mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_valid_i, mem_data_i
  );

endinterface : w0rm_peripheral_bus_arbiter_if

// File: rtl/w0rm_peripheral_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention the
// requester that was not granted last wins.
module w0rm_rr_arb2
  import w0rm_periph_bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  // One-hot grant selection
  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule : w0rm_rr_arb2

// File: rtl/w0rm_peripheral_bus_arbiter.sv
// Arbitrates two requesters onto a single peripheral bus with one
// transaction outstanding and a bounded wait for the peripheral acknowledge.
module w0rm_peripheral_bus_arbiter
  import w0rm_periph_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           mem_clk,
  input  logic                           cpu_reset,
  w0rm_peripheral_bus_arbiter_if.slave   bus
);

  // Timeout must fit the 8-bit counter and be nonzero
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  logic                   last_q, last_d;      // index of last granted requester
  cmd_t                   cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     accept_c;
  logic                   issue_c;
  logic                   resp_c;

  assign req = {bus.m1_valid_i, bus.m0_valid_i};

  w0rm_rr_arb2 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // Accept is only offered from IDLE and is held off while reset is asserted
  assign accept_c = gnt & {NUM_REQ{(state_q == ST_IDLE) && cpu_reset}};

  // State and captured transaction registers
  always_ff @(posedge mem_clk or negedge cpu_reset) begin
    if (!cpu_reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, capture and timeout logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q >= TIMEOUT_C) ? TIMEOUT_C : cnt_q + CNT_WIDTH'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          state_d = ST_ISSUE;
          last_d  = gnt[1];
          if (gnt[1]) begin
            cmd_d   = '{rd: bus.m1_read_i, wr: bus.m1_write_i};
            addr_d  = bus.m1_addr_i;
            wdata_d = bus.m1_data_i;
          end else begin
            cmd_d   = '{rd: bus.m0_read_i, wr: bus.m0_write_i};
            addr_d  = bus.m0_addr_i;
            wdata_d = bus.m0_data_i;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Acknowledge takes priority over a coincident timeout
        if (bus.mem_valid_i) begin
          rdata_d = bus.mem_data_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign issue_c = (state_q == ST_ISSUE);
  assign resp_c  = (state_q == ST_RESP);

  // Requester-side outputs
  assign bus.m0_accept_o = accept_c[0];
  assign bus.m1_accept_o = accept_c[1];
  assign bus.m0_valid_o  = resp_c & ~last_q;
  assign bus.m1_valid_o  = resp_c &  last_q;
  assign bus.m0_data_o   = bus.m0_valid_o ? rdata_q : '0;
  assign bus.m1_data_o   = bus.m1_valid_o ? rdata_q : '0;
  assign bus.m0_err_o    = bus.m0_valid_o & err_q;
  assign bus.m1_err_o    = bus.m1_valid_o & err_q;

  // Peripheral-side outputs
  assign bus.mem_valid_o = issue_c;
  assign bus.mem_read_o  = issue_c & cmd_q.rd;
  assign bus.mem_write_o = issue_c & cmd_q.wr;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_data_o  = wdata_q;

endmodule : w0rm_peripheral_bus_arbiter

// File: tb/tb_w0rm_peripheral_bus_arbiter.sv
// Scoreboard bench for the two-requester peripheral bus arbiter.
module tb_w0rm_peripheral_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic        mem_clk = 1'b0;
  logic        cpu_reset = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  w0rm_peripheral_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  w0rm_peripheral_bus_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .mem_clk   (mem_clk),
    .cpu_reset (cpu_reset),
    .bus       (bus)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit port, input bit v, input bit rd, input bit wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port) begin
      bus.m1_valid_i = v; bus.m1_read_i = rd; bus.m1_write_i = wr;
      bus.m1_addr_i = addr; bus.m1_data_i = wdata;
    end else begin
      bus.m0_valid_i = v; bus.m0_read_i = rd; bus.m0_write_i = wr;
      bus.m0_addr_i = addr; bus.m0_data_i = wdata;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":accepts"}, 64'({bus.m0_accept_o, bus.m1_accept_o}), 64'(0));
    check({tag, ":mem_ctl"}, 64'({bus.mem_valid_o, bus.mem_read_o, bus.mem_write_o}), 64'(0));
    check({tag, ":mem_addr"}, 64'(bus.mem_addr_o), 64'(0));
    check({tag, ":mem_data"}, 64'(bus.mem_data_o), 64'(0));
    check({tag, ":resp_valid"}, 64'({bus.m0_valid_o, bus.m1_valid_o}), 64'(0));
  endtask

  // One full transaction; ack_at is the WAIT cycle carrying the ack (0 = none),
  // nwait is the hand-computed number of WAIT cycles before the response.
  task automatic do_txn(input bit port, input bit rd, input bit wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int ack_at, input logic [DW-1:0] ack_data,
                        input bit spurious, input int nwait,
                        input logic [DW-1:0] exp_data, input bit exp_err,
                        input string tag);
    exp_t e;
    e.port = port; e.data = exp_data; e.err = exp_err;
    @(negedge mem_clk);
    cpu_reset = 1'b1;
    drive_req(port, 1'b1, rd, wr, addr, wdata);
    #1;
    check({tag, ":accept"}, 64'(port ? bus.m1_accept_o : bus.m0_accept_o), 64'(1));
    check({tag, ":other_accept"}, 64'(port ? bus.m0_accept_o : bus.m1_accept_o), 64'(0));
    exp_q.push_back(e);
    @(negedge mem_clk);
    drive_req(port, 1'b0, 1'b0, 1'b0, '0, '0);
    bus.mem_valid_i = spurious;
    bus.mem_data_i  = spurious ? 32'h0000_0BAD : 32'h0;
    #1;
    check({tag, ":mem_valid"}, 64'(bus.mem_valid_o), 64'(1));
    check({tag, ":mem_rw"}, 64'({bus.mem_read_o, bus.mem_write_o}), 64'({rd, wr}));
    check({tag, ":mem_addr"}, 64'(bus.mem_addr_o), 64'(addr));
    check({tag, ":mem_data"}, 64'(bus.mem_data_o), 64'(wdata));
    for (int w = 1; w <= nwait; w++) begin
      @(negedge mem_clk);
      bus.mem_valid_i = (w == ack_at);
      bus.mem_data_i  = (w == ack_at) ? ack_data : 32'h5A5A_5A5A;
      #1;
      if (w == 1)
        check({tag, ":mem_valid_drop"}, 64'({bus.mem_valid_o, bus.mem_read_o, bus.mem_write_o}), 64'(0));
    end
    @(negedge mem_clk);
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = '0;
    #1;
    check({tag, ":resp_strobe"}, 64'(port ? bus.m1_valid_o : bus.m0_valid_o), 64'(1));
  endtask

  // Monitor: pops expected responses whenever a response strobe appears
  always @(negedge mem_clk) begin
    #2;
    check("accept_onehot", 64'(bus.m0_accept_o & bus.m1_accept_o), 64'(0));
    if (bus.m0_valid_o || bus.m1_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got m0_valid=%0b m1_valid=%0b, expected none",
                 bus.m0_valid_o, bus.m1_valid_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_single", 64'(bus.m0_valid_o & bus.m1_valid_o), 64'(0));
        check("resp_port", 64'(bus.m1_valid_o), 64'(mon_e.port));
        check("resp_data", 64'(bus.m1_valid_o ? bus.m1_data_o : bus.m0_data_o), 64'(mon_e.data));
        check("resp_err", 64'(bus.m1_valid_o ? bus.m1_err_o : bus.m0_err_o), 64'(mon_e.err));
        check("resp_other_zero",
              64'(bus.m1_valid_o ? {bus.m0_data_o, bus.m0_err_o} : {bus.m1_data_o, bus.m1_err_o}),
              64'(0));
      end
    end else begin
      check("idle_resp_zero",
            64'(|{bus.m0_data_o, bus.m0_err_o, bus.m1_data_o, bus.m1_err_o}), 64'(0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_seq;
    bit         p;
    exp_seq = 4'b1010;

    drive_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = '0;

    // Reset state, with a request pending that must not be accepted
    repeat (2) @(negedge mem_clk);
    drive_req(1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_0000, '0);
    #1;
    check_all_zero("reset");
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Basic read released on the first edge after reset
    do_txn(1'b0, 1'b1, 1'b0, 32'h8000_0088, 32'h0, 1, 32'h0000_00A5, 1'b0, 1,
           32'h0000_00A5, 1'b0, "rd_m0");
    // Write by requester 1 returns the ack data
    do_txn(1'b1, 1'b0, 1'b1, 32'h8000_008C, 32'h0000_00FF, 1, 32'h1234_5678, 1'b0, 1,
           32'h1234_5678, 1'b0, "wr_m1");
    // No acknowledge: error after the full wait window
    do_txn(1'b0, 1'b1, 1'b0, 32'h9000_0000, 32'h0, 0, 32'h0, 1'b0, 15,
           32'h0, 1'b1, "timeout_m0");
    // Normal service after a timeout
    do_txn(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 1,
           32'hCAFE_F00D, 1'b0, "after_to_m1");
    // Ack coincident with the timeout boundary wins
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 15, 32'hDEAD_BEEF, 1'b0, 15,
           32'hDEAD_BEEF, 1'b0, "ack_at_to");
    // Ack one cycle before the boundary
    do_txn(1'b1, 1'b1, 1'b0, 32'h0000_004C, 32'h0, 14, 32'h0000_1414, 1'b0, 14,
           32'h0000_1414, 1'b0, "ack_before_to");
    // Ack during ISSUE is ignored; the real ack comes later
    do_txn(1'b0, 1'b0, 1'b1, 32'h0000_0048, 32'h0000_0011, 3, 32'h600D_F00D, 1'b1, 3,
           32'h600D_F00D, 1'b0, "ignore_early_ack");

    // Reset during WAIT abandons the transaction
    @(negedge mem_clk);
    drive_req(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0050, '0);
    #1;
    check("rst_mid:accept", 64'(bus.m0_accept_o), 64'(1));
    @(negedge mem_clk);
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge mem_clk);
    cpu_reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (3) @(negedge mem_clk);
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0054, 32'h0, 1, 32'h0000_0077, 1'b0, 1,
           32'h0000_0077, 1'b0, "after_rst");

    // Continuous contention from reset: grants alternate m0, m1, m0, m1
    @(negedge mem_clk);
    cpu_reset = 1'b0;
    drive_req(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, '0);
    drive_req(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, '0);
    #1;
    check("rr_reset:accepts", 64'({bus.m1_accept_o, bus.m0_accept_o}), 64'(0));
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      p = exp_seq[k];
      @(negedge mem_clk);
      cpu_reset = 1'b1;
      #1;
      check("rr:accepts", 64'({bus.m1_accept_o, bus.m0_accept_o}), p ? 64'(2) : 64'(1));
      e.port = p; e.data = 32'h100 + 32'(k); e.err = 1'b0;
      exp_q.push_back(e);
      @(negedge mem_clk);
      #1;
      check("rr:mem_addr", 64'(bus.mem_addr_o), p ? 64'(32'h200) : 64'(32'h100));
      check("rr:issue_no_accept", 64'({bus.m1_accept_o, bus.m0_accept_o}), 64'(0));
      @(negedge mem_clk);
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = 32'h100 + 32'(k);
      #1;
      check("rr:wait_no_accept", 64'({bus.m1_accept_o, bus.m0_accept_o}), 64'(0));
      @(negedge mem_clk);
      bus.mem_valid_i = 1'b0;
      bus.mem_data_i  = '0;
      #1;
      check("rr:resp_no_accept", 64'({bus.m1_accept_o, bus.m0_accept_o}), 64'(0));
    end
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

    repeat (3) @(negedge mem_clk);
    #3;
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_w0rm_peripheral_bus_arbiter
